fault_inject_seq: RTL

FAULT_INJECT_SEQ -- requirements
Module: fault_inject_seq

---
 rtl/fault_inject_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fault_inject_seq.sv
// Fault-injection sequencer: after a programmable delay it drives one cell override
// (stuck-at-0, stuck-at-1 or bit-flip) for a programmable number of cycles.
module fault_inject_seq #(
  parameter int unsigned N_TGT = 8,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned TW   = (N_TGT > 1) ? $clog2(N_TGT) : 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic [TW-1:0]    TGT,
  input  logic [1:0]       MODE,
  input  logic [CNT_W-1:0] DELAY,
  input  logic [CNT_W-1:0] DURATION,
  input  logic [N_TGT-1:0] OBS,
  output logic [N_TGT-1:0] FORCE_F,
  output logic [N_TGT-1:0] FORCE_V,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {StIdle, StArm, StInject, StFinish} state_e;

  state_e           state_q;
  logic [TW-1:0]    tgt_q;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] dur_q;
  logic [CNT_W-1:0] cnt_q;
  logic             flip_q;
  logic [N_TGT-1:0] force_f_q;
  logic [N_TGT-1:0] force_v_q;
  logic             busy_q;
  logic             done_q;

  logic [TW-1:0] tgt_sel;
  logic          obs_bit;
  logic          inj_val;

  // In IDLE the target is not yet latched, so a zero-delay bit-flip samples via TGT.
  assign tgt_sel = (state_q == StIdle) ? TGT : tgt_q;

  always_comb begin
    obs_bit = 1'b0;
    for (int i = 0; i < N_TGT; i++) begin
      if (int'(tgt_sel) == i) obs_bit = OBS[i];
    end
  end

  always_comb begin
    unique case (mode_q)
      2'b01:   inj_val = 1'b1;
      2'b10:   inj_val = flip_q;
      default: inj_val = 1'b0;
    endcase
  end

  // Outputs are registered from the current state, so they trail the state by one edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      tgt_q     <= '0;
      mode_q    <= 2'b00;
      dur_q     <= '0;
      cnt_q     <= '0;
      flip_q    <= 1'b0;
      force_f_q <= '0;
      force_v_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      force_f_q <= '0;
      force_v_q <= '0;
      busy_q    <= ((state_q == StArm) || (state_q == StInject)) && !ABORT;
      done_q    <= (state_q == StFinish);
      if ((state_q == StInject) && !ABORT) begin
        // Out-of-range targets match no index and leave the override idle.
        for (int i = 0; i < N_TGT; i++) begin
          if (int'(tgt_q) == i) begin
            force_f_q[i] <= 1'b1;
            force_v_q[i] <= inj_val;
          end
        end
      end

      unique case (state_q)
        StIdle: begin
          if (START && !ABORT) begin
            tgt_q  <= TGT;
            mode_q <= MODE;
            dur_q  <= DURATION;
            if (DELAY != '0) begin
              state_q <= StArm;
              cnt_q   <= DELAY;
            end else if (DURATION != '0) begin
              state_q <= StInject;
              cnt_q   <= DURATION;
              flip_q  <= ~obs_bit;
            end else begin
              state_q <= StFinish;
            end
          end
        end
        StArm: begin
          if (ABORT) begin
            state_q <= StFinish;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_W'(1)) begin
            if (dur_q != '0) begin
              state_q <= StInject;
              cnt_q   <= dur_q;
              flip_q  <= ~obs_bit;
            end else begin
              state_q <= StFinish;
              cnt_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StInject: begin
          if (ABORT || (cnt_q == CNT_W'(1))) begin
            state_q <= StFinish;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign FORCE_F = force_f_q;
  assign FORCE_V = force_v_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;

endmodule
